// File: rtl/l1_mem_arbiter_pkg.sv
// Shared constants for the L1 block-memory arbiter: FSM states, op codes, default widths.
// Default widths fall back to the config-header macros when the header is not included.
`ifndef DMEM_BLOCK_ADDR_SIZE
`define DMEM_BLOCK_ADDR_SIZE 26
`endif
`ifndef DBLOCK_SIZE_BITS
`define DBLOCK_SIZE_BITS 128
`endif

package l1_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } arbState_t;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   localparam int DEF_ADDR_W  = `DMEM_BLOCK_ADDR_SIZE;
   localparam int DEF_BLOCK_W = `DBLOCK_SIZE_BITS;

   // Grant-id width; a single channel still needs one bit of storage.
   function automatic int idWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/l1_mem_arbiter_rr_picker.sv
// Combinational rotating-priority selector: first requester at or after ptr wins.
// With L1ARB_FIXED_PRIO_EN defined it degenerates to lowest-index priority.
module rr_picker #(
   parameter int NUM_CH = 2,
   parameter int ID_W   = 1
) (
   input  logic [NUM_CH-1:0] reqVec,
   input  logic [ID_W-1:0]   ptr,
   output logic [ID_W-1:0]   winner,
   output logic              anyValid
);

`ifdef L1ARB_FIXED_PRIO_EN
   logic unusedPtr;
   assign unusedPtr = ^ptr;

   always_comb begin
      winner   = '0;
      anyValid = 1'b0;
      // Descending scan so the lowest requesting index is the last write.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (reqVec[i]) begin
            winner   = ID_W'(i);
            anyValid = 1'b1;
         end
      end
   end
`else
   int idx;

   always_comb begin
      winner   = '0;
      anyValid = 1'b0;
      idx      = 0;
      // Descending offset scan: the smallest offset from ptr is written last and wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_CH;
         if (reqVec[idx]) begin
            winner   = ID_W'(idx);
            anyValid = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/l1_mem_arbiter.sv
// N-channel arbiter sharing one main-memory block port between the L1 cache controllers.
// Round-robin by default; define L1ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module l1_mem_arbiter
   import l1_mem_arbiter_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BLOCK_W = DEF_BLOCK_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         req_ren,
   input  logic [NUM_CH-1:0]         req_wen,
   input  logic [NUM_CH*ADDR_W-1:0]  req_addr,
   input  logic [NUM_CH*BLOCK_W-1:0] req_din,
   output logic [NUM_CH-1:0]         req_read_ready,
   output logic [NUM_CH-1:0]         req_write_done,
   output logic [BLOCK_W-1:0]        req_dout,
   output logic                      mem_ren,
   output logic                      mem_wen,
   output logic [ADDR_W-1:0]         mem_block_address,
   output logic [BLOCK_W-1:0]        mem_din,
   input  logic                      mem_read_ready,
   input  logic                      mem_write_done,
   input  logic [BLOCK_W-1:0]        mem_dout,
   output logic                      busy
);

   localparam int ID_W = idWidth(NUM_CH);

   arbState_t          state, stateNext;
   logic [ID_W-1:0]    ptr, winner, grantId;
   logic               anyValid, grant, memDone;
   logic               opQ, doneRd, doneWr;
   logic [ADDR_W-1:0]  addrQ;
   logic [BLOCK_W-1:0] dinQ, doutQ;
   logic [NUM_CH-1:0]  eligible;
   logic [ADDR_W-1:0]  chAddr [NUM_CH];
   logic [BLOCK_W-1:0] chDin  [NUM_CH];

   assign eligible = req_ren | req_wen;

   for (genvar i = 0; i < NUM_CH; i++) begin : gUnpack
      assign chAddr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign chDin[i]  = req_din[i*BLOCK_W +: BLOCK_W];
   end

   rr_picker #(
      .NUM_CH (NUM_CH),
      .ID_W   (ID_W)
   ) uPicker (
      .reqVec   (eligible),
      .ptr      (ptr),
      .winner   (winner),
      .anyValid (anyValid)
   );

   // Only the pulse matching the latched op can end a transaction.
   assign memDone = (opQ == OP_WR) ? mem_write_done : mem_read_ready;

   always_comb begin
      stateNext = state;
      grant     = 1'b0;
      case (state)
         IDLE: begin
            if (anyValid) begin
               stateNext = ISSUE;
               grant     = 1'b1;
            end
         end
         ISSUE:   if (memDone) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         grantId <= '0;
         opQ     <= OP_RD;
         addrQ   <= '0;
         dinQ    <= '0;
         doutQ   <= '0;
      end else begin
         state <= stateNext;
         if (grant) begin
            grantId <= winner;
            // A channel asking for both gets its write first; the read stays pending.
            opQ     <= req_wen[winner] ? OP_WR : OP_RD;
            addrQ   <= chAddr[winner];
            dinQ    <= chDin[winner];
         end
         if (state == ISSUE && opQ == OP_RD && mem_read_ready)
            doutQ <= mem_dout;
      end
   end

`ifdef L1ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   always_ff @(posedge clock) begin
      if (reset)
         ptr <= '0;
      else if (grant)
         ptr <= (winner == ID_W'(NUM_CH - 1)) ? '0 : winner + ID_W'(1);
   end
`endif

   assign mem_ren           = (state == ISSUE) && (opQ == OP_RD);
   assign mem_wen           = (state == ISSUE) && (opQ == OP_WR);
   assign mem_block_address = addrQ;
   assign mem_din           = dinQ;
   assign req_dout          = doutQ;
   assign busy              = (state != IDLE);

   assign doneRd = (state == DONE) && (opQ == OP_RD);
   assign doneWr = (state == DONE) && (opQ == OP_WR);

   for (genvar i = 0; i < NUM_CH; i++) begin : gResp
      assign req_read_ready[i] = doneRd && (grantId == ID_W'(i));
      assign req_write_done[i] = doneWr && (grantId == ID_W'(i));
   end

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Scoreboard bench for l1_mem_arbiter (3 channels): memory model and response monitor
// pop expectations pushed by the directed stimulus.
`timescale 1ns/1ps
module tb_l1_mem_arbiter;

   localparam int NCH = 3;
   localparam int AW  = 8;
   localparam int BW  = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [NCH-1:0]    req_ren = '0;
   logic [NCH-1:0]    req_wen = '0;
   logic [NCH*AW-1:0] req_addr = '0;
   logic [NCH*BW-1:0] req_din = '0;
   logic [NCH-1:0]    req_read_ready, req_write_done;
   logic [BW-1:0]     req_dout, mem_din;
   logic [BW-1:0]     mem_dout = '0;
   logic              mem_ren, mem_wen, busy;
   logic              mem_read_ready = 1'b0;
   logic              mem_write_done = 1'b0;
   logic [AW-1:0]     mem_block_address;

   always #5 clock = ~clock;

   l1_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .BLOCK_W(BW)) dut (
      .clock             (clock),
      .reset             (reset),
      .req_ren           (req_ren),
      .req_wen           (req_wen),
      .req_addr          (req_addr),
      .req_din           (req_din),
      .req_read_ready    (req_read_ready),
      .req_write_done    (req_write_done),
      .req_dout          (req_dout),
      .mem_ren           (mem_ren),
      .mem_wen           (mem_wen),
      .mem_block_address (mem_block_address),
      .mem_din           (mem_din),
      .mem_read_ready    (mem_read_ready),
      .mem_write_done    (mem_write_done),
      .mem_dout          (mem_dout),
      .busy              (busy)
   );

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [BW-1:0] din;
   } memExp_t;

   typedef struct {
      logic          wr;
      int            ch;
      logic [BW-1:0] data;
   } respExp_t;

   memExp_t  expMem[$];
   respExp_t expResp[$];
   int       vectors = 0;
   int       miscompares = 0;
   int       memLat = 3;
   logic     spurRd = 1'b0;

`ifdef L1ARB_FIXED_PRIO_EN
   localparam int CONT_N = 5;
   int contOrder[CONT_N] = '{0, 0, 0, 0, 0};
   int wrapOrder[6]      = '{0, 0, 0, 0, 0, 0};
`else
   localparam int CONT_N = 4;
   int contOrder[CONT_N] = '{0, 1, 0, 1};
   int wrapOrder[6]      = '{0, 1, 2, 0, 1, 2};
`endif

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory: strobe for memLat cycles, then one completion pulse; read data = C0DE0000 | addr.
   initial begin : memModel
      int            cnt;
      logic [AW-1:0] a0;
      logic [BW-1:0] d0;
      logic          w0;
      memExp_t       e;
      cnt = 0;
      a0  = '0;
      d0  = '0;
      w0  = 1'b0;
      forever begin
         @(negedge clock);
         mem_read_ready = 1'b0;
         mem_write_done = 1'b0;
         if (reset) begin
            cnt = 0;
         end else if (mem_ren || mem_wen) begin
            cnt++;
            if (cnt == 1) begin
               a0 = mem_block_address;
               d0 = mem_din;
               w0 = mem_wen;
               if (expMem.size() == 0) begin
                  check("mem unexpected access", 1, 0);
               end else begin
                  e = expMem.pop_front();
                  check("mem op", w0, e.wr);
                  check("mem addr", a0, e.addr);
                  if (e.wr) check("mem din", d0, e.din);
               end
               if (w0 && spurRd) mem_read_ready = 1'b1;
            end else begin
               check("mem addr stable", mem_block_address, a0);
               check("mem din stable", mem_din, d0);
               check("mem op stable", mem_wen, w0);
            end
            if (cnt == memLat) begin
               if (w0) begin
                  mem_write_done = 1'b1;
               end else begin
                  mem_read_ready = 1'b1;
                  mem_dout       = 32'hC0DE_0000 | {24'h0, a0};
               end
               cnt = 0;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin : respMon
      respExp_t       e;
      logic [NCH-1:0] v;
      forever begin
         @(negedge clock);
         v = req_read_ready | req_write_done;
         if (!reset && (|v)) begin
            check("resp onehot", ($countones(v) == 1) && !((|req_read_ready) && (|req_write_done)), 1);
            if (expResp.size() == 0) begin
               check("resp unexpected", 1, 0);
            end else begin
               e = expResp.pop_front();
               check("resp ch", v, NCH'(1) << e.ch);
               check("resp op", |req_write_done, e.wr);
               if (!e.wr) check("resp data", req_dout, e.data);
            end
         end
      end
   end

   task automatic setReq(input int ch, input logic ren, input logic wen,
                         input logic [AW-1:0] a, input logic [BW-1:0] d);
      req_addr[ch*AW +: AW] = a;
      req_din[ch*BW +: BW]  = d;
      req_ren[ch]           = ren;
      req_wen[ch]           = wen;
   endtask

   // Wait for a specific channel pulse; latency counted in cycles after the request cycle.
   task automatic waitResp(input int ch, input logic wr, input int expLat);
      int n;
      bit seen;
      n    = 0;
      seen = 0;
      while (!seen && n < 60) begin
         @(negedge clock);
         #1;
         n++;
         if (wr ? req_write_done[ch] : req_read_ready[ch]) seen = 1;
      end
      check("resp timeout", seen, 1);
      if (expLat > 0) check("resp latency", n, expLat);
      if (wr) req_wen[ch] = 1'b0;
      else    req_ren[ch] = 1'b0;
   endtask

   task automatic waitAny(input int total);
      int n, got;
      n   = 0;
      got = 0;
      while (got < total && n < 300) begin
         @(negedge clock);
         #1;
         n++;
         if ((|req_read_ready) || (|req_write_done)) got++;
      end
      check("rounds timeout", got, total);
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      check({tag, " mem_ren"}, mem_ren, 0);
      check({tag, " mem_wen"}, mem_wen, 0);
      check({tag, " read_ready"}, req_read_ready, 0);
      check({tag, " write_done"}, req_write_done, 0);
      check({tag, " req_dout"}, req_dout, 0);
      check({tag, " mem_addr"}, mem_block_address, 0);
      check({tag, " mem_din"}, mem_din, 0);
      check({tag, " busy"}, busy, 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      repeat (3) @(negedge clock);
      #1;
      checkIdleOutputs("reset");
      reset = 1'b0;

      // Single read, ch1 @0x10: strobe cycles 1-3, pulse in cycle 4.
      expMem.push_back('{1'b0, 8'h10, 32'h0});
      expResp.push_back('{1'b0, 1, 32'hC0DE_0010});
      setReq(1, 1'b1, 1'b0, 8'h10, 32'h0);
      waitResp(1, 1'b0, 4);

      // Contention from reset: ch0 @0x20 and ch1 @0x21 continuously requesting.
      doReset();
      foreach (contOrder[i]) begin
         expMem.push_back('{1'b0, 8'(32'h20 + contOrder[i]), 32'h0});
         expResp.push_back('{1'b0, contOrder[i], 32'hC0DE_0020 + contOrder[i]});
      end
      setReq(0, 1'b1, 1'b0, 8'h20, 32'h0);
      setReq(1, 1'b1, 1'b0, 8'h21, 32'h0);
      waitAny(CONT_N);
      req_ren = '0;

      // Wrap-around: all three channels continuously requesting @0x50+ch.
      doReset();
      foreach (wrapOrder[i]) begin
         expMem.push_back('{1'b0, 8'(32'h50 + wrapOrder[i]), 32'h0});
         expResp.push_back('{1'b0, wrapOrder[i], 32'hC0DE_0050 + wrapOrder[i]});
      end
      for (int c = 0; c < NCH; c++) setReq(c, 1'b1, 1'b0, 8'(32'h50 + c), 32'h0);
      waitAny(6);
      req_ren = '0;

      // Write ch0 @0x2A with a spurious read pulse mid-write.
      @(negedge clock);
      #1;
      spurRd = 1'b1;
      expMem.push_back('{1'b1, 8'h2A, 32'hA5A5_A5A5});
      expResp.push_back('{1'b1, 0, 32'h0});
      setReq(0, 1'b0, 1'b1, 8'h2A, 32'hA5A5_A5A5);
      waitResp(0, 1'b1, 4);
      spurRd = 1'b0;

      // ren+wen on ch2: write first, read re-arbitrated afterwards.
      @(negedge clock);
      #1;
      expMem.push_back('{1'b1, 8'h33, 32'h1234_5678});
      expMem.push_back('{1'b0, 8'h33, 32'h0});
      expResp.push_back('{1'b1, 2, 32'h0});
      expResp.push_back('{1'b0, 2, 32'hC0DE_0033});
      setReq(2, 1'b1, 1'b1, 8'h33, 32'h1234_5678);
      waitResp(2, 1'b1, 4);
      waitResp(2, 1'b0, 5);

      // Reset during ISSUE: abandoned silently, then a fresh read is served.
      @(negedge clock);
      #1;
      memLat = 10;
      expMem.push_back('{1'b0, 8'h44, 32'h0});
      setReq(1, 1'b1, 1'b0, 8'h44, 32'h0);
      repeat (3) @(negedge clock);
      #1;
      check("mid busy", busy, 1);
      check("mid mem_ren", mem_ren, 1);
      reset   = 1'b1;
      req_ren = '0;
      @(negedge clock);
      #1;
      checkIdleOutputs("midreset");
      reset  = 1'b0;
      memLat = 3;
      expMem.push_back('{1'b0, 8'h45, 32'h0});
      expResp.push_back('{1'b0, 1, 32'hC0DE_0045});
      setReq(1, 1'b1, 1'b0, 8'h45, 32'h0);
      waitResp(1, 1'b0, 4);

      repeat (5) @(negedge clock);
      #1;
      check("expMem drained", expMem.size(), 0);
      check("expResp drained", expResp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Parametrised N-channel block-memory arbiter between the L1 cache controllers (icache fill, dcache fill/write-back, future extra channels) and the single shared main-memory block port. Each channel presents a block-wide read or write request with a hold-until-acknowledged handshake. One transaction is in flight at a time, granted round-robin. Responses are routed back to the granted channel only. Replaces the direct controller-to-memory wiring in the cpu top so both caches share one memory port.

## Interface
Parameters:
- NUM_CH, 2: number of requester channels, 1..8; channel 0 is the dcache.
- ADDR_W, `DMEM_BLOCK_ADDR_SIZE`: block address width.
- BLOCK_W, `DBLOCK_SIZE_BITS`: block data width.

Ports (clock and reset first):
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_ren  in  NUM_CH  per-channel read request, held until `req_read_ready`.
- req_wen  in  NUM_CH  per-channel write request, held until `req_write_done`.
- req_addr  in  NUM_CH*ADDR_W  per-channel block address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_din  in  NUM_CH*BLOCK_W  per-channel write data, same packing.
- req_read_ready  out  NUM_CH  one-cycle read-complete pulse to the granted channel.
- req_write_done  out  NUM_CH  one-cycle write-complete pulse to the granted channel.
- req_dout  out  BLOCK_W  registered read data, valid in the `req_read_ready` cycle; shared by all channels.
- mem_ren  out  1  memory read strobe.
- mem_wen  out  1  memory write strobe.
- mem_block_address  out  ADDR_W  memory block address.
- mem_din  out  BLOCK_W  memory write data.
- mem_read_ready  in  1  memory read-complete pulse.
- mem_write_done  in  1  memory write-complete pulse.
- mem_dout  in  BLOCK_W  memory read data, valid with `mem_read_ready`.
- busy  out  1  high while a transaction is granted (ISSUE or DONE).

## Operation
- States:
  - IDLE: sample the requests. If any channel is eligible, pick the winner, latch its id, op, address and data, then go to ISSUE.
  - ISSUE: drive `mem_ren` or `mem_wen` from the latched values. On the matching memory completion pulse, go to DONE.
  - DONE: pulse the channel response for one cycle, then go to IDLE.
- Eligible channel: `req_ren[i] | req_wen[i]`.
- If a channel asserts both ren and wen, the write is serviced. Its read stays pending and is re-arbitrated in a later round.
- Round-robin: pointer `ptr` starts at 0. The winner is the first eligible channel scanning `ptr, ptr+1, ...` modulo NUM_CH. After a grant, `ptr <= winner+1`, wrapping NUM_CH-1 to 0.
- Memory outputs come from the latched registers, not from the live requests. Requester changes during ISSUE have no effect.
- Completion matching:
  - In ISSUE, only the pulse matching the latched op completes the transaction.
  - A non-matching pulse is ignored.
  - Any `mem_read_ready` or `mem_write_done` pulse in IDLE or DONE is ignored.
- On read completion, `req_dout <= mem_dout` in the same edge that enters DONE.
- NUM_CH=1: the arbiter degenerates to a registered pass-through and the pointer stays 0.
- Grant-id width is max(1, clog2(NUM_CH)).

## Timing
- Reset values: state IDLE; `ptr` 0; all outputs 0, including `req_dout`.
- Reset mid-transaction abandons the transaction silently, with no response pulse. Main memory shares the same reset.
- Request first high in cycle t (state IDLE) → `mem_ren`/`mem_wen` high from t+1.
- Memory pulse in cycle k → memory strobe low and response pulse high in cycle k+1 → state IDLE in k+2.
- The requester drops its request in k+2, so IDLE never regrants a stale request.
- Overhead is 2 cycles over memory latency; back-to-back grants are possible every (memory latency + 2) cycles.
- Simultaneous requests in one IDLE cycle: exactly one grant. The loser remains held and is granted in the next IDLE.
- The memory strobe stays high continuously through ISSUE until its completion pulse.

## Configuration
- `L1ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest channel index wins. `ptr` is not implemented. Channel 0 (dcache) can starve the others.
  - Undefined (default): round-robin as above, with no starvation. With every channel continuously requesting, each channel is granted within NUM_CH rounds.

## Structure
- Shared constants header:
  - State encodings IDLE=2'd0, ISSUE=2'd1, DONE=2'd2.
  - Op encoding OP_RD=1'b0, OP_WR=1'b1.
  - Default width macros, which come from the existing config header.
- Sub-module `rr_picker`: combinational rotating-priority selector.
  - Inputs: request vector, `ptr`.
  - Outputs: winner index, `any_valid`.
  - Compiled as plain lowest-index priority when `L1ARB_FIXED_PRIO_EN` is defined.
- Top module: FSM, latch registers, response demux.

## Test plan
- Single read: ch1 reads addr 0x10, memory latency 3.
  - `mem_ren` high in cycles 1-3.
  - `req_read_ready[1]` pulses in cycle 4 with `req_dout` = memory data.
  - `req_read_ready[0]` stays 0.
- Contention: ch0 and ch1 both request in cycle 0 from reset (`ptr`=0). Grant order ch0, ch1. A further ch0+ch1 request then grants ch1 first only if ch1 is pending and `ptr`=1; alternation is checked over 4 rounds.
- Wrap-around: NUM_CH=3, all channels continuously requesting → grant order 0,1,2,0,1,2.
- Write: ch0 writes addr 0x2A with data 0xA5 repeated.
  - `mem_wen`, address and data are stable until `mem_write_done`.
  - `req_write_done[0]` pulses once.
  - A spurious `mem_read_ready` during the write is ignored.
- Reset mid-transaction: reset asserted during ISSUE → next cycle all outputs 0, state IDLE, no response pulse. A new request is then served normally.
- Fixed-priority build: with the macro defined, ch0 requesting continuously starves ch1 over 5 rounds.
